// File: rtl/reg_pkg.sv
// Shared helpers for the reg_pipe pipeline register chain.
package reg_pkg;

    // Bits needed to count 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One valid+data register stage of reg_pipe; loads from its source whenever its ready is high.
module reg_pipe_stage
    import reg_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VALUE;
        end else if (flush) begin
            // Flush drops items but leaves payload registers untouched.
            r_valid <= 1'b0;
        end else if (ready) begin
            r_valid <= src_valid;
            if (src_valid) begin
                r_data <= src_data;
            end
        end
    end

    assign valid = r_valid;
    assign data  = r_data;

endmodule

// File: rtl/reg_pipe.sv
// DEPTH-stage valid/ready pipeline with bubble collapsing.
// Optional synchronous flush input enabled by defining REG_PIPE_FLUSH_EN.
module reg_pipe
    import reg_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           reset,
`ifdef REG_PIPE_FLUSH_EN
    input  logic                           flush,
`endif
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [cnt_width(DEPTH)-1:0]    occupancy
);

    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [DEPTH-1:0] w_valid;
    logic [DEPTH:0]   w_ready;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic             w_flush;
    logic [CNT_W-1:0] w_occ;

`ifdef REG_PIPE_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_ready[DEPTH] = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             w_src_valid;
        logic [WIDTH-1:0] w_src_data;

        if (i == 0) begin : g_head
            assign w_src_valid = in_valid;
            assign w_src_data  = in_data;
        end else begin : g_body
            assign w_src_valid = w_valid[i-1];
            assign w_src_data  = w_data[i-1];
        end

        // A stage can take new data if it is empty or its content moves on.
        assign w_ready[i] = !w_valid[i] || w_ready[i+1];

        reg_pipe_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .flush     (w_flush),
            .src_valid (w_src_valid),
            .src_data  (w_src_data),
            .ready     (w_ready[i]),
            .valid     (w_valid[i]),
            .data      (w_data[i])
        );
    end

    always_comb begin
        w_occ = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + CNT_W'(w_valid[i]);
        end
    end

    assign in_ready  = w_ready[0] && !reset && !w_flush;
    assign out_valid = w_valid[DEPTH-1] && !reset;
    assign out_data  = w_data[DEPTH-1];
    assign occupancy = w_occ;

endmodule

// File: tb/tb_reg_pipe.sv
// Self-checking bench for reg_pipe (WIDTH=8, DEPTH=3): item-position model plus directed checks.
module tb_reg_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] occupancy;

    int total = 0;
    int bad = 0;

    reg_pipe #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .RESET_VALUE (8'd0)
    ) u_dut (
        .clk       (clk),
`ifdef REG_PIPE_FLUSH_EN
        .flush     (flush),
`endif
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Model: items in FIFO order, each with the stage index it occupies.
    int q_data[$];
    int q_pos[$];
    int m_last = 0;
    bit m_init = 1'b0;

    function automatic bit m_in_ready();
        return !reset && !flush && ((q_data.size() < DEPTH) || out_ready);
    endfunction

    function automatic bit m_out_valid();
        return !reset && (q_data.size() > 0) && (q_pos[0] == DEPTH - 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit pop;
        bit push;
        int prev;
        int np;
        if (reset) begin
            q_data.delete();
            q_pos.delete();
            m_last = 0;
            m_init = 1'b1;
        end else if (flush) begin
            q_data.delete();
            q_pos.delete();
        end else begin
            pop  = m_out_valid() && out_ready;
            push = in_valid && m_in_ready();
            if (pop) begin
                void'(q_data.pop_front());
                void'(q_pos.pop_front());
            end
            // Each item advances one stage unless the item ahead is adjacent and stuck.
            prev = DEPTH;
            for (int k = 0; k < q_data.size(); k++) begin
                np = (q_pos[k] + 1 < prev - 1) ? q_pos[k] + 1 : prev - 1;
                q_pos[k] = np;
                if (np == DEPTH - 1) m_last = q_data[k];
                prev = np;
            end
            if (push) begin
                q_data.push_back(int'(in_data));
                q_pos.push_back(0);
                if (DEPTH == 1) m_last = int'(in_data);
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("in_ready", int'(in_ready), int'(m_in_ready()));
            chk("out_valid", int'(out_valid), int'(m_out_valid()));
            chk("out_data", int'(out_data), m_last);
            chk("occupancy", int'(occupancy), q_data.size());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        // Reset with an item offered; it must never be accepted.
        reset = 1'b1; in_valid = 1'b1; in_data = 8'd99; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        ticks(2);
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_out_data", int'(out_data), 0);
        chk("post_rst_occ", int'(occupancy), 0);
        chk("post_rst_in_ready", int'(in_ready), 1);
        tick();

        // Streaming 10..13 with the consumer always ready.
        in_valid = 1'b1; in_data = 8'd10;
        tick(); in_data = 8'd11;
        tick(); in_data = 8'd12;
        @(negedge clk);
        chk("stream_lat_valid", int'(out_valid), 0);
        tick(); in_data = 8'd13;
        @(negedge clk);
        chk("stream_first_valid", int'(out_valid), 1);
        chk("stream_first_data", int'(out_data), 10);
        chk("stream_occ", int'(occupancy), 3);
        tick(); in_valid = 1'b0;
        @(negedge clk);
        chk("stream_second_data", int'(out_data), 11);
        ticks(4);

        // Backpressure fill, then simultaneous pop and push.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'd1;
        tick(); in_data = 8'd2;
        tick(); in_data = 8'd3;
        tick(); in_data = 8'd4;
        @(negedge clk);
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_occ", int'(occupancy), 3);
        chk("full_out_data", int'(out_data), 1);
        tick();
        @(negedge clk);
        chk("full_hold_data", int'(out_data), 1);
        chk("full_hold_valid", int'(out_valid), 1);
        tick(); out_ready = 1'b1;
        @(negedge clk);
        chk("full_release_in_ready", int'(in_ready), 1);
        tick(); in_valid = 1'b0;
        @(negedge clk);
        chk("pop_push_data", int'(out_data), 2);
        chk("pop_push_occ", int'(occupancy), 3);
        tick(); tick();
        @(negedge clk);
        chk("fill_last_data", int'(out_data), 4);
        ticks(2);

        // Bubble collapse under stall.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'd5;
        tick(); in_valid = 1'b0;
        tick(); in_valid = 1'b1; in_data = 8'd6;
        tick(); in_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("bubble_occ", int'(occupancy), 2);
        chk("bubble_out_data", int'(out_data), 5);
        chk("bubble_mid_stage", int'(u_dut.g_stage[1].u_stage.data), 6);
        tick(); out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("bubble_second", int'(out_data), 6);
        chk("bubble_second_valid", int'(out_valid), 1);
        ticks(2);

        // Reset in the middle of traffic.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'd8;
        tick(); in_data = 8'd9;
        tick(); in_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("mid_pre_occ", int'(occupancy), 2);
        tick(); reset = 1'b1; in_valid = 1'b1; in_data = 8'd7;
        @(negedge clk);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        tick(); reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("mid_post_occ", int'(occupancy), 0);
        chk("mid_post_valid", int'(out_valid), 0);
        chk("mid_post_data", int'(out_data), 0);
        tick(); out_ready = 1'b1;
        ticks(3);
        @(negedge clk);
        chk("mid_item7_dropped", int'(occupancy), 0);
        tick();

`ifdef REG_PIPE_FLUSH_EN
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'd20;
        tick(); in_data = 8'd21;
        tick(); in_data = 8'd22;
        tick(); flush = 1'b1; in_data = 8'd23;
        @(negedge clk);
        chk("flush_in_ready", int'(in_ready), 0);
        chk("flush_out_valid", int'(out_valid), 1);
        tick(); flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_occ", int'(occupancy), 0);
        chk("flush_valid", int'(out_valid), 0);
        chk("flush_data", int'(out_data), 20);
        tick(); out_ready = 1'b1; in_valid = 1'b1; in_data = 8'd30;
        tick(); in_valid = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("flush_after_valid", int'(out_valid), 1);
        chk("flush_after_data", int'(out_data), 30);
        chk("flush_after_occ", int'(occupancy), 1);
        ticks(2);
        @(negedge clk);
        chk("flush_drained_occ", int'(occupancy), 0);
`endif

        ticks(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
